// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// PC step size and the default boot address.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its environment (hazard unit,
// branch resolution, instruction memory and the decode stage).
//
// Handshake rules: the memory has no back-pressure. IM_REQ is a one-cycle
// strobe; IM_RDATA must be valid in exactly the cycle after IM_REQ was high
// and is ignored at any other time. VALID_D qualifies PC_D/PCPlus4_D/INSTR_D;
// when VALID_D is 0 the decode stage must treat the register as a bubble.
// PCWrite/IMRead/FDWrite are level stall controls, sampled every cycle.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic         PCWrite;
  logic         IMRead;
  logic         FDWrite;
  logic         Redirect;
  logic [31:0]  RedirectPC;
  logic         IM_REQ;
  logic [31:0]  IM_ADDR;
  logic [31:0]  IM_RDATA;
  logic [31:0]  PC_D;
  logic [31:0]  PCPlus4_D;
  logic [31:0]  INSTR_D;
  logic         VALID_D;
  fetch_state_e state_dbg;

  // Environment side: drives controls and memory data, observes fetch results.
  modport master (
    output PCWrite, IMRead, FDWrite, Redirect, RedirectPC, IM_RDATA,
    input  IM_REQ, IM_ADDR, PC_D, PCPlus4_D, INSTR_D, VALID_D, state_dbg
  );

  // Fetch unit side.
  modport slave (
    input  PCWrite, IMRead, FDWrite, Redirect, RedirectPC, IM_RDATA,
    output IM_REQ, IM_ADDR, PC_D, PCPlus4_D, INSTR_D, VALID_D, state_dbg
  );

endinterface : fetch_unit_if

// File: rtl/fetch_skid.sv
// One-entry buffer that parks a returned instruction word while decode is
// stalled. Clear beats load, load beats drain.
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // Buffer occupancy and payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule : fetch_skid

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory request strobe,
// IF/ID pipeline register and a one-entry hold buffer for words that return
// while decode is stalled.
// Optional feature macro: FETCH_PERF_EN adds saturating FetchCnt/BubbleCnt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic         CLK,
  input logic         RSTN,
  fetch_unit_if.slave fif
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] BubbleCnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pending_q, pending_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  pcd_q, pcd_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         im_req;

  logic         skid_load, skid_drain, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  fetch_skid u_skid (
    .clk     (CLK),
    .rst_n   (RSTN),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .pc_i    (req_pc_q),
    .instr_i (fif.IM_RDATA),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign im_req = fif.IMRead & fif.PCWrite & (state_q == RUN) & ~fif.Redirect;

  // State, PC, request tracking and IF/ID register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      req_pc_q  <= '0;
      pcd_q     <= '0;
      pcp4_q    <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      req_pc_q  <= req_pc_d;
      pcd_q     <= pcd_d;
      pcp4_q    <= pcp4_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state: redirect wins, then returning data, then the hold buffer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = im_req;
    req_pc_d   = im_req ? pc_q : req_pc_q;
    pcd_d      = pcd_q;
    pcp4_d     = pcp4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (im_req) pc_d = pc_q + PC_INC;

    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = state_q;
    endcase

    if (fif.Redirect) begin
      pc_d       = fif.RedirectPC;
      pending_d  = 1'b0;
      skid_clear = 1'b1;
      state_d    = RUN;
      valid_d    = 1'b0;
    end else if (pending_q) begin
      if (skid_valid) begin
        // A second word arrived behind a parked one. Hand the parked word to
        // decode and park the new one; if decode is still stalled the new
        // word is dropped and the PC rewinds so it gets fetched again.
        if (fif.FDWrite) begin
          pcd_d     = skid_pc;
          pcp4_d    = skid_pc + PC_INC;
          instr_d   = skid_instr;
          valid_d   = 1'b1;
          skid_load = 1'b1;
        end else begin
          pc_d = req_pc_q;
        end
      end else if (fif.FDWrite) begin
        pcd_d   = req_pc_q;
        pcp4_d  = req_pc_q + PC_INC;
        instr_d = fif.IM_RDATA;
        valid_d = 1'b1;
      end else begin
        skid_load = 1'b1;
        state_d   = HOLD;
      end
    end else if (skid_valid) begin
      if (fif.FDWrite) begin
        pcd_d      = skid_pc;
        pcp4_d     = skid_pc + PC_INC;
        instr_d    = skid_instr;
        valid_d    = 1'b1;
        skid_drain = 1'b1;
        state_d    = RUN;
      end
    end else if (fif.FDWrite) begin
      valid_d = 1'b0;
    end
  end

  assign fif.IM_REQ    = im_req;
  assign fif.IM_ADDR   = pc_q;
  assign fif.PC_D      = pcd_q;
  assign fif.PCPlus4_D = pcp4_q;
  assign fif.INSTR_D   = instr_q;
  assign fif.VALID_D   = valid_q;
  assign fif.state_dbg = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        bubble_wr;

  // A bubble is any cycle that writes VALID_D=0 into IF/ID.
  assign bubble_wr = fif.Redirect |
                     (fif.FDWrite & ~pending_q & ~skid_valid);

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (im_req && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble_wr && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic CLK;
  logic RSTN;
  fetch_unit_if fif ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .fif  (fif)
`ifdef FETCH_PERF_EN
    ,
    .FetchCnt  (fetch_cnt),
    .BubbleCnt (bubble_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- instruction memory ----------------
  logic        mem_pend;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h8) return 32'h00A0_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_pend <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_pend <= fif.IM_REQ;
      mem_addr <= fif.IM_ADDR;
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } fw_t;

  logic [31:0] m_pc;
  logic        m_boot;
  logic [31:0] exp_q[$];   // addresses requested, data due next cycle
  fw_t         m_buf[$];   // words parked while decode is stalled
  logic [31:0] e_pcd, e_pcp4, e_instr;
  logic        e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_boot  = 1'b1;
    exp_q.delete();
    m_buf.delete();
    e_pcd   = '0;
    e_pcp4  = '0;
    e_instr = '0;
    e_valid = 1'b0;
  endtask

  task automatic load_ifid(input fw_t w);
    e_pcd   = w.pc;
    e_pcp4  = w.pc + 32'd4;
    e_instr = w.word;
    e_valid = 1'b1;
  endtask

  // One cycle of the fetch stage at transaction level.
  task automatic model_step(input logic fdw, input logic rd, input logic [31:0] rdpc,
                            input logic req);
    fw_t got;
    bit  have;
    have = 0;
    if (rd) begin
      m_pc = rdpc;
      exp_q.delete();
      m_buf.delete();
      e_valid = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        got.pc   = exp_q.pop_front();
        got.word = mem_word(got.pc);
        have     = 1;
      end
      if (have && fdw)              load_ifid(got);
      else if (have)                m_buf.push_back(got);
      else if (m_buf.size() > 0 && fdw) load_ifid(m_buf.pop_front());
      else if (fdw)                 e_valid = 1'b0;
      if (req) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic pcw, input logic imr, input logic fdw,
                       input logic rd, input logic [31:0] rdpc);
    logic exp_req;
    fif.PCWrite    = pcw;
    fif.IMRead     = imr;
    fif.FDWrite    = fdw;
    fif.Redirect   = rd;
    fif.RedirectPC = rdpc;
    fif.IM_RDATA   = mem_pend ? mem_word(mem_addr) : $urandom();
    #1;
    exp_req = imr & pcw & ~rd & ~m_boot & (m_buf.size() == 0);
    chk("im_req", {31'd0, fif.IM_REQ}, {31'd0, exp_req});
    chk("im_addr", fif.IM_ADDR, m_pc);
    model_step(fdw, rd, rdpc, exp_req);
    @(negedge CLK);
    chk("valid_d", {31'd0, fif.VALID_D}, {31'd0, e_valid});
    chk("pc_d", fif.PC_D, e_pcd);
    chk("pcplus4_d", fif.PCPlus4_D, e_pcp4);
    chk("instr_d", fif.INSTR_D, e_instr);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset pulse mid-cycle, outputs checked while held low.
  task automatic do_reset();
    #3 RSTN = 1'b0;
    #1;
    chk("rst_im_req", {31'd0, fif.IM_REQ}, 32'd0);
    chk("rst_im_addr", fif.IM_ADDR, RST_PC);
    chk("rst_valid_d", {31'd0, fif.VALID_D}, 32'd0);
    chk("rst_pc_d", fif.PC_D, 32'd0);
    chk("rst_pcplus4_d", fif.PCPlus4_D, 32'd0);
    chk("rst_instr_d", fif.INSTR_D, 32'd0);
    chk("rst_state", 32'(fif.state_dbg), 32'(BOOT));
`ifdef FETCH_PERF_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
    @(negedge CLK);
    RSTN = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_pcw, r_imr, r_fdw, r_rd, r_stall;
    logic [31:0] r_pc;
    int          r;

    RSTN           = 1'b1;
    fif.PCWrite    = 1'b0;
    fif.IMRead     = 1'b0;
    fif.FDWrite    = 1'b0;
    fif.Redirect   = 1'b0;
    fif.RedirectPC = '0;
    fif.IM_RDATA   = '0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // Boot and straight-line fetch: 0, 4, 8 from the second cycle.
    run(3);
    chk("first_valid", {31'd0, fif.VALID_D}, 32'd1);
    chk("first_pc_d", fif.PC_D, 32'h0);
    run(2);
    chk("addr8_instr", fif.INSTR_D, 32'h00A0_0093);
    chk("addr8_pc_d", fif.PC_D, 32'h8);
    chk("addr8_pcplus4", fif.PCPlus4_D, 32'hC);

    // Decode stall while word 0xC returns: parked in the hold buffer.
    for (int i = 0; i < 3; i++) begin
      stall(1);
      chk("hold_state", 32'(fif.state_dbg), 32'(HOLD));
      chk("hold_instr_kept", fif.INSTR_D, 32'h00A0_0093);
    end
    run(1);
    chk("drain_pc_d", fif.PC_D, 32'hC);
    chk("drain_valid", {31'd0, fif.VALID_D}, 32'd1);
    chk("resume_addr", fif.IM_ADDR, 32'h10);
    chk("resume_state", 32'(fif.state_dbg), 32'(RUN));

    // Redirect with a request in flight.
    run(2);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    chk("redir_valid", {31'd0, fif.VALID_D}, 32'd0);
    chk("redir_addr", fif.IM_ADDR, 32'h100);
    run(3);

    // Redirect while decode stalled: bubble regardless of FDWrite.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("redir_stall_valid", {31'd0, fif.VALID_D}, 32'd0);
    run(2);

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    run(2);
    chk("wrap_addr", fif.IM_ADDR, 32'h0);
    run(3);

    // Bubble insertion: FDWrite=1 with nothing fetched.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("bubble_valid", {31'd0, fif.VALID_D}, 32'd0);
    run(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r       = $urandom_range(0, 15);
      r_rd    = (r == 0);
      r_stall = (r >= 1 && r <= 3);
      r_fdw   = !r_stall;
      r_pcw   = r_stall ? 1'b0 : ($urandom_range(0, 7) != 0);
      r_imr   = ($urandom_range(0, 7) != 0);
      r_pc    = $urandom() & 32'hFFFF_FFFC;
      if (r_rd && ($urandom_range(0, 3) == 0)) r_pc = 32'hFFFF_FFF0;
      cycle(r_pcw, r_imr, r_fdw, r_rd, r_pc);
    end

    // Reset pulse during HOLD, then reboot.
    run(2);
    stall(2);
    chk("pre_reset_hold", 32'(fif.state_dbg), 32'(HOLD));
    do_reset();
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_unit
